// File: rtl/pps_div_regs_if.sv
// pps_div_regs_if: register bus shared by the pps_div data sources
interface pps_div_regs_if;
  logic [7:0] addr;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  modport master(output addr, wr_en, wr_data, rd_en, input rd_data);
  modport slave(input addr, wr_en, wr_data, rd_en, output rd_data);
endinterface

// File: rtl/pps_div_regs.sv
// pps_div_regs: register-mapped PPS divider; PPS-loss detector is built only when PPS_DIV_LOSS_DET_EN is defined
module pps_div_regs #(
  parameter logic [7:0]  BASE_ADDR   = 8'h10,
  parameter logic [31:0] TIMEOUT_CYC = 32'd0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_pps,
  pps_div_regs_if.slave bus,
  output logic          o_pps_div,
  output logic [7:0]    o_pulse_cnt
);
  typedef enum logic [1:0] {IDLE, ARMED, PULSE} state_t;
  state_t state, state_n;
  logic [2:0] sync;
  logic en, inv, lock, loss, loss_set, pcnt_inc;
  logic sel, wr_sel, wr_ctrl, restart, pps_edge, term;
  logic [2:0] off;
  logic [15:0] div, cnt, cnt_n;
  logic [7:0] width, wcnt, wcnt_n, wid, rd_mux;
  assign sel      = bus.addr[7:3] == BASE_ADDR[7:3];
  assign off      = bus.addr[2:0];
  assign wr_sel   = sel && bus.wr_en;
  assign wr_ctrl  = wr_sel && off == 3'd0;
  assign restart  = wr_ctrl && bus.wr_data[2];
  assign pps_edge = sync[1] && !sync[2];
  assign wid      = width == 8'd0 ? 8'd1 : width;
  // N-1 with N=0 treated as N=1; >= lets a lowered N fire on the next edge
  assign term     = cnt >= (div == 16'd0 ? 16'd0 : div - 16'd1);
  assign rd_mux   = off == 3'd0 ? {6'd0, inv, en} :
                    off == 3'd1 ? div[7:0] :
                    off == 3'd2 ? div[15:8] :
                    off == 3'd3 ? width :
                    off == 3'd4 ? {6'd0, loss, lock} :
                    off == 3'd5 ? o_pulse_cnt : 8'd0;
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    wcnt_n   = wcnt;
    pcnt_inc = 1'b0;
    if (restart) begin
      state_n = bus.wr_data[0] ? ARMED : IDLE;
      cnt_n   = '0;
    end else if (!en) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (state == IDLE) begin
      state_n = ARMED;
    end else begin
      if (state == PULSE) begin
        wcnt_n  = wcnt - 8'd1;
        state_n = wcnt <= 8'd1 ? ARMED : PULSE;
      end
      if (pps_edge) begin
        cnt_n    = term ? 16'd0 : cnt + 16'd1;
        wcnt_n   = term ? wid : wcnt_n;
        state_n  = term ? PULSE : state_n;
        pcnt_inc = term;
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      sync        <= '0;
      state       <= IDLE;
      cnt         <= '0;
      wcnt        <= '0;
      en          <= 1'b0;
      inv         <= 1'b0;
      div         <= 16'd1;
      width       <= 8'd1;
      lock        <= 1'b0;
      o_pps_div   <= 1'b0;
      o_pulse_cnt <= '0;
      bus.rd_data <= '0;
    end else begin
      sync        <= {sync[1:0], i_pps};
      state       <= state_n;
      cnt         <= cnt_n;
      wcnt        <= wcnt_n;
      o_pulse_cnt <= o_pulse_cnt + {7'd0, pcnt_inc};
      o_pps_div   <= (state == PULSE && en && !restart) ^ inv;
      lock        <= loss_set ? 1'b0 : (en && pps_edge) ? 1'b1 :
                     (wr_ctrl && bus.wr_data[0] && !en) ? 1'b0 : lock;
      bus.rd_data <= sel && bus.rd_en ? rd_mux : 8'd0;
      if (wr_ctrl) begin
        en  <= bus.wr_data[0];
        inv <= bus.wr_data[1];
      end
      if (wr_sel && off == 3'd1) div[7:0] <= bus.wr_data;
      if (wr_sel && off == 3'd2) div[15:8] <= bus.wr_data;
      if (wr_sel && off == 3'd3) width <= bus.wr_data;
    end
`ifdef PPS_DIV_LOSS_DET_EN
  logic [31:0] idle;
  assign loss_set = en && TIMEOUT_CYC != 32'd0 && !pps_edge && idle == TIMEOUT_CYC - 32'd1;
  // idle saturates at the timeout so LOSS is set once per outage
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      idle <= '0;
      loss <= 1'b0;
    end else begin
      idle <= (pps_edge || !en) ? 32'd0 :
              (TIMEOUT_CYC != 32'd0 && idle != TIMEOUT_CYC) ? idle + 32'd1 : idle;
      loss <= loss_set || (loss && !(wr_sel && off == 3'd4 && bus.wr_data[1]));
    end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign loss_set = 1'b0;
  assign loss     = 1'b0;
`endif
endmodule
